// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM pipeline: datapath widths,
// control bundle bit positions and the NOP control word.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    // Bit positions inside the decoded control bundle
    localparam int MEM_READ_BIT  = 0;
    localparam int REG_WRITE_BIT = 1;
    localparam int MEM_WRITE_BIT = 2;
    localparam int BRANCH_BIT    = 3;
    localparam int JUMP_BIT      = 4;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0]        REG_X0   = 5'd0;

    // True when a writeback to wAddr should replace the operand read from rAddr
    function automatic logic wbHits(input logic       wbWe,
                                    input logic [4:0] wbAddr,
                                    input logic [4:0] rAddr);
        return wbWe && (wbAddr != REG_X0) && (wbAddr == rAddr);
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX bundle: ID-stage fields, writeback port snoop and EX-stage outputs.
// master = ID/WB side (drives fields, sees EX outputs), slave = pipeline register.
interface id_ex_if;
    import pipe_pkg::*;

    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic [4:0]        id_rd_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    logic              wb_we;
    logic [4:0]        wb_waddr;
    logic [XLEN-1:0]   wb_wd;

    logic              load_use_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1_addr;
    logic [4:0]        ex_rs2_addr;
    logic [4:0]        ex_rd_addr;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid_i, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_we, wb_waddr, wb_wd,
        input  load_use_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl
    );

    modport slave (
        input  id_valid_i, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_we, wb_waddr, wb_wd,
        output load_use_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl
    );

endinterface

// File: rtl/id_ex_pipe_reg_opnd_sel.sv
// Per-operand selector: x0 forces zero, a matching writeback replaces
// the supplied data, otherwise the supplied data passes through.
module id_ex_opnd_sel
    import pipe_pkg::*;
(
    input  logic [4:0]      i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_waddr,
    input  logic [XLEN-1:0] i_wb_wd,
    output logic [XLEN-1:0] o_data
);

    // x0 beats writeback, writeback beats the supplied value
    always_comb begin
        o_data = i_data;
        if (i_addr == REG_X0) begin
            o_data = '0;
        end else if (wbHits(i_wb_we, i_wb_waddr, i_addr)) begin
            o_data = i_wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches the ID instruction into EX with
// writeback bypass, load-use bubble insertion, external stall and flush.
// Optional macro ID_EX_PERF_EN adds saturating bubble/stall counters.
module id_ex_pipe_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
`ifdef ID_EX_PERF_EN
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_stalls,
`endif
    id_ex_if.slave      bus
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1_addr;
    logic [4:0]        r_rs2_addr;
    logic [4:0]        r_rd_addr;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_load_use;
    logic [XLEN-1:0]   w_cap_rs1;
    logic [XLEN-1:0]   w_cap_rs2;
    logic [XLEN-1:0]   w_hold_rs1;
    logic [XLEN-1:0]   w_hold_rs2;

    // Capture path: ID operands with same-cycle writeback substituted
    id_ex_opnd_sel u_cap_rs1 (
        .i_addr     (bus.id_rs1_addr),
        .i_data     (bus.id_rs1_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_waddr (bus.wb_waddr),
        .i_wb_wd    (bus.wb_wd),
        .o_data     (w_cap_rs1)
    );

    id_ex_opnd_sel u_cap_rs2 (
        .i_addr     (bus.id_rs2_addr),
        .i_data     (bus.id_rs2_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_waddr (bus.wb_waddr),
        .i_wb_wd    (bus.wb_wd),
        .o_data     (w_cap_rs2)
    );

    // Hold path: keeps stalled EX operands fresh as writebacks retire
    id_ex_opnd_sel u_hold_rs1 (
        .i_addr     (r_rs1_addr),
        .i_data     (r_rs1_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_waddr (bus.wb_waddr),
        .i_wb_wd    (bus.wb_wd),
        .o_data     (w_hold_rs1)
    );

    id_ex_opnd_sel u_hold_rs2 (
        .i_addr     (r_rs2_addr),
        .i_data     (r_rs2_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_waddr (bus.wb_waddr),
        .i_wb_wd    (bus.wb_wd),
        .o_data     (w_hold_rs2)
    );

    // A load in EX whose destination feeds the ID instruction cannot be bypassed yet
    always_comb begin
        w_load_use = r_valid && r_ctrl[MEM_READ_BIT] && (r_rd_addr != REG_X0) &&
                     bus.id_valid_i &&
                     ((r_rd_addr == bus.id_rs1_addr) || (r_rd_addr == bus.id_rs2_addr));
    end

    // Pipeline register update: flush > stall > load-use bubble > capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_ctrl     <= CTRL_NOP;
        end else if (flush_i || (!stall_i && w_load_use)) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_ctrl     <= CTRL_NOP;
        end else if (stall_i) begin
            r_rs1_data <= w_hold_rs1;
            r_rs2_data <= w_hold_rs2;
        end else begin
            r_valid    <= bus.id_valid_i;
            r_pc       <= bus.id_pc;
            r_rs1_data <= w_cap_rs1;
            r_rs2_data <= w_cap_rs2;
            r_imm      <= bus.id_imm;
            r_rs1_addr <= bus.id_rs1_addr;
            r_rs2_addr <= bus.id_rs2_addr;
            r_rd_addr  <= bus.id_rd_addr;
            r_ctrl     <= bus.id_valid_i ? bus.id_ctrl : CTRL_NOP;
        end
    end

    assign bus.load_use_stall = w_load_use;
    assign bus.ex_valid       = r_valid;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_rs1_data    = r_rs1_data;
    assign bus.ex_rs2_data    = r_rs2_data;
    assign bus.ex_imm         = r_imm;
    assign bus.ex_rs1_addr    = r_rs1_addr;
    assign bus.ex_rs2_addr    = r_rs2_addr;
    assign bus.ex_rd_addr     = r_rd_addr;
    assign bus.ex_ctrl        = r_ctrl;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_stalls;

    // Saturating counters; only load-use bubbles count, flush bubbles do not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_bubbles <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (!flush_i && !stall_i && w_load_use && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
            if (stall_i && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg: reset, writeback bypass, x0,
// load-use bubbles, stall hold-update and priority between controls.
// Counter checks run when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    logic stall_i;
    logic flush_i;
    int   nChecks;
    int   nFails;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_stalls;
`endif

    id_ex_if bus ();

    id_ex_pipe_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
`ifdef ID_EX_PERF_EN
        .perf_bubbles (perf_bubbles),
        .perf_stalls  (perf_stalls),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveId(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [15:0] ctrl);
        bus.id_valid_i  = v;
        bus.id_pc       = pc;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_addr = rs2;
        bus.id_rd_addr  = rd;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_ctrl     = ctrl;
    endtask

    task automatic driveWb(input logic we, input logic [4:0] addr, input logic [31:0] wd);
        bus.wb_we    = we;
        bus.wb_waddr = addr;
        bus.wb_wd    = wd;
    endtask

    // Advance one edge and settle outputs away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        driveWb(1'b0, 5'd0, 32'h0);
        driveId(1'b1, 32'h0000_0040, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'h33, 16'h0006);
        tick();
        nChecks++;
        if (bus.ex_pc !== 32'h40) begin
            nFails++; $display("[TB] FAIL reset_precap_pc: got %h want %h", bus.ex_pc, 32'h40);
        end
        stall_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        nChecks++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
             bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr, bus.ex_ctrl} !== '0) begin
            nFails++; $display("[TB] FAIL reset_async_clear: valid=%b pc=%h rs1=%h ctrl=%h want all 0",
                               bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_ctrl);
        end
        @(negedge clk);
        stall_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_capture_bypass();
        driveId(1'b1, 32'h100, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'h4, 16'h0002);
        driveWb(1'b1, 5'd5, 32'hABCD);
        tick();
        nChecks++;
        if (bus.ex_rs1_data !== 32'hABCD) begin
            nFails++; $display("[TB] FAIL bypass_rs1: got %h want %h", bus.ex_rs1_data, 32'hABCD);
        end
        nChecks++;
        if (bus.ex_rs2_data !== 32'h22) begin
            nFails++; $display("[TB] FAIL bypass_rs2_untouched: got %h want %h", bus.ex_rs2_data, 32'h22);
        end
        nChecks++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_rd_addr, bus.ex_ctrl, bus.ex_imm} !==
            {1'b1, 32'h100, 5'd8, 16'h0002, 32'h4}) begin
            nFails++; $display("[TB] FAIL capture_fields: valid=%b pc=%h rd=%0d ctrl=%h imm=%h want 1 100 8 0002 4",
                               bus.ex_valid, bus.ex_pc, bus.ex_rd_addr, bus.ex_ctrl, bus.ex_imm);
        end
        driveId(1'b1, 32'h104, 5'd9, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 16'h0002);
        driveWb(1'b1, 5'd9, 32'h77);
        tick();
        nChecks++;
        if ({bus.ex_rs1_data, bus.ex_rs2_data} !== {32'h77, 32'h77}) begin
            nFails++; $display("[TB] FAIL bypass_both: got %h/%h want 77/77", bus.ex_rs1_data, bus.ex_rs2_data);
        end
        driveId(1'b1, 32'h108, 5'd9, 5'd11, 5'd10, 32'h1, 32'h2, 32'h0, 16'h0002);
        driveWb(1'b0, 5'd9, 32'h77);
        tick();
        nChecks++;
        if (bus.ex_rs1_data !== 32'h1) begin
            nFails++; $display("[TB] FAIL bypass_we_low: got %h want %h", bus.ex_rs1_data, 32'h1);
        end
        driveId(1'b0, 32'h10C, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 16'hFFFF);
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl} !== {1'b0, 16'h0000}) begin
            nFails++; $display("[TB] FAIL invalid_id_nop: valid=%b ctrl=%h want 0 0000", bus.ex_valid, bus.ex_ctrl);
        end
    endtask

    task automatic test_x0();
        driveId(1'b1, 32'h200, 5'd4, 5'd0, 5'd12, 32'h44, 32'hFFFF, 32'h0, 16'h0002);
        driveWb(1'b1, 5'd0, 32'h1234);
        tick();
        nChecks++;
        if (bus.ex_rs2_data !== 32'h0) begin
            nFails++; $display("[TB] FAIL x0_forced_zero: got %h want 0", bus.ex_rs2_data);
        end
        nChecks++;
        if (bus.ex_rs1_data !== 32'h44) begin
            nFails++; $display("[TB] FAIL x0_wb_ignored: got %h want %h", bus.ex_rs1_data, 32'h44);
        end
        driveWb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_load_use();
        driveId(1'b1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h10, 32'h20, 32'h0, 16'h0003);
        tick();
        driveId(1'b1, 32'h304, 5'd3, 5'd7, 5'd9, 32'h30, 32'hDEAD, 32'h8, 16'h0004);
        #1;
        nChecks++;
        if (bus.load_use_stall !== 1'b1) begin
            nFails++; $display("[TB] FAIL load_use_detect: got %b want 1", bus.load_use_stall);
        end
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.load_use_stall} !== {1'b0, 16'h0000, 1'b0}) begin
            nFails++; $display("[TB] FAIL load_use_bubble: valid=%b ctrl=%h stall=%b want 0 0000 0",
                               bus.ex_valid, bus.ex_ctrl, bus.load_use_stall);
        end
        driveWb(1'b1, 5'd7, 32'hCAFE);
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_rs2_data, bus.ex_rd_addr, bus.ex_ctrl} !==
            {1'b1, 32'h304, 32'hCAFE, 5'd9, 16'h0004}) begin
            nFails++; $display("[TB] FAIL load_use_recapture: valid=%b pc=%h rs2=%h rd=%0d ctrl=%h want 1 304 cafe 9 0004",
                               bus.ex_valid, bus.ex_pc, bus.ex_rs2_data, bus.ex_rd_addr, bus.ex_ctrl);
        end
        driveWb(1'b0, 5'd0, 32'h0);
        // load to x0 and a non-load writing x7 must not stall
        driveId(1'b1, 32'h308, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0001);
        tick();
        driveId(1'b1, 32'h30C, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 16'h0002);
        #1;
        nChecks++;
        if (bus.load_use_stall !== 1'b0) begin
            nFails++; $display("[TB] FAIL load_use_rd_x0: got %b want 0", bus.load_use_stall);
        end
        driveId(1'b1, 32'h310, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 16'h0002);
        tick();
        driveId(1'b1, 32'h314, 5'd7, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 16'h0002);
        #1;
        nChecks++;
        if (bus.load_use_stall !== 1'b0) begin
            nFails++; $display("[TB] FAIL load_use_non_load: got %b want 0", bus.load_use_stall);
        end
    endtask

    task automatic test_stall_hold();
        driveId(1'b1, 32'h400, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'hC, 16'h0008);
        tick();
        stall_i = 1'b1;
        driveId(1'b1, 32'h999, 5'd13, 5'd14, 5'd15, 32'hBAD, 32'hBAD, 32'hBAD, 16'h0002);
        tick();
        nChecks++;
        if ({bus.ex_pc, bus.ex_rs1_data, bus.ex_ctrl} !== {32'h400, 32'h1, 16'h0008}) begin
            nFails++; $display("[TB] FAIL stall_hold_c1: pc=%h rs1=%h ctrl=%h want 400 1 0008",
                               bus.ex_pc, bus.ex_rs1_data, bus.ex_ctrl);
        end
        driveWb(1'b1, 5'd3, 32'h55);
        tick();
        nChecks++;
        if ({bus.ex_rs1_data, bus.ex_rs2_data} !== {32'h55, 32'h2}) begin
            nFails++; $display("[TB] FAIL stall_hold_update: rs1=%h rs2=%h want 55 2", bus.ex_rs1_data, bus.ex_rs2_data);
        end
        driveWb(1'b0, 5'd0, 32'h0);
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_imm} !== {1'b1, 32'h400, 32'h55, 32'hC}) begin
            nFails++; $display("[TB] FAIL stall_hold_c3: valid=%b pc=%h rs1=%h imm=%h want 1 400 55 c",
                               bus.ex_valid, bus.ex_pc, bus.ex_rs1_data, bus.ex_imm);
        end
        stall_i = 1'b0;
    endtask

    task automatic test_priority();
        driveId(1'b1, 32'h500, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 16'h0002);
        tick();
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_pc} !== {1'b0, 16'h0000, 32'h0}) begin
            nFails++; $display("[TB] FAIL flush_over_stall: valid=%b ctrl=%h pc=%h want 0 0000 0",
                               bus.ex_valid, bus.ex_ctrl, bus.ex_pc);
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        driveId(1'b1, 32'h504, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h0, 16'h0001);
        tick();
        driveId(1'b1, 32'h508, 5'd7, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 16'h0002);
        stall_i = 1'b1;
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_pc} !== {1'b1, 16'h0001, 32'h504}) begin
            nFails++; $display("[TB] FAIL stall_over_load_use: valid=%b ctrl=%h pc=%h want 1 0001 504",
                               bus.ex_valid, bus.ex_ctrl, bus.ex_pc);
        end
        stall_i = 1'b0;
        flush_i = 1'b1;
        #1;
        nChecks++;
        if (bus.load_use_stall !== 1'b1) begin
            nFails++; $display("[TB] FAIL flush_lu_detect: got %b want 1", bus.load_use_stall);
        end
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl} !== {1'b0, 16'h0000}) begin
            nFails++; $display("[TB] FAIL flush_over_load_use: valid=%b ctrl=%h want 0 0000", bus.ex_valid, bus.ex_ctrl);
        end
        flush_i = 1'b0;
        driveId(1'b1, 32'h50C, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 16'h0002);
        flush_i = 1'b1;
        tick();
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl} !== {1'b0, 16'h0000}) begin
            nFails++; $display("[TB] FAIL flush_over_capture: valid=%b ctrl=%h want 0 0000", bus.ex_valid, bus.ex_ctrl);
        end
        flush_i = 1'b0;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        #1;
        nChecks++;
        if ({perf_bubbles, perf_stalls} !== 64'h0) begin
            nFails++; $display("[TB] FAIL perf_reset: bubbles=%0d stalls=%0d want 0 0", perf_bubbles, perf_stalls);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            driveId(1'b1, 32'h600, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 16'h0001);
            tick();
            driveId(1'b1, 32'h604, 5'd7, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, 16'h0002);
            tick();
        end
        driveId(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        stall_i = 1'b0;
        tick();
        nChecks++;
        if ({perf_bubbles, perf_stalls} !== {32'd4, 32'd6}) begin
            nFails++; $display("[TB] FAIL perf_counts: bubbles=%0d stalls=%0d want 4 6", perf_bubbles, perf_stalls);
        end
    endtask
`endif

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        driveId(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        driveWb(1'b0, 5'd0, 32'h0);
        #12;
        nChecks++;
        if ({bus.ex_valid, bus.ex_ctrl} !== {1'b0, 16'h0000}) begin
            nFails++; $display("[TB] FAIL initial_reset: valid=%b ctrl=%h want 0 0000", bus.ex_valid, bus.ex_ctrl);
        end
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_capture_bypass();
        test_x0();
        test_load_use();
        test_stall_hold();
        test_priority();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
